// File: rtl/s2mm_channel_fifo_if.sv
// Stream-in / FWFT-read bundle for one S2MM channel FIFO.
// The slave modport is the FIFO side and the master modport is the source/filter side.
interface s2mm_channel_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] SRC_AXIS_tdata_in;
    logic                  SRC_AXIS_tlast_in;
    logic                  SRC_AXIS_tvalid_in;
    logic                  SRC_AXIS_tready_out;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_last_out;
    logic                  fifo_not_empty_out;
    logic                  fifo_r_stb_in;
    logic [ADDR_WIDTH:0]   fifo_level_out;
    logic [ADDR_WIDTH:0]   pkt_count_out;
    logic [15:0]           underflow_cnt_out;

    modport slave (
        input  SRC_AXIS_tdata_in,
        input  SRC_AXIS_tlast_in,
        input  SRC_AXIS_tvalid_in,
        output SRC_AXIS_tready_out,
        output fifo_data_out,
        output fifo_last_out,
        output fifo_not_empty_out,
        input  fifo_r_stb_in,
        output fifo_level_out,
        output pkt_count_out,
        output underflow_cnt_out
    );

    modport master (
        output SRC_AXIS_tdata_in,
        output SRC_AXIS_tlast_in,
        output SRC_AXIS_tvalid_in,
        input  SRC_AXIS_tready_out,
        input  fifo_data_out,
        input  fifo_last_out,
        input  fifo_not_empty_out,
        output fifo_r_stb_in,
        input  fifo_level_out,
        input  pkt_count_out,
        input  underflow_cnt_out
    );
endinterface

// File: rtl/s2mm_channel_fifo.sv
// Per-channel packet FIFO feeding one slot of the S2MM packet filter.
// First-word-fall-through read port. In store-and-forward mode a head word is only
// advertised once a whole packet is held, unless an oversize packet forces cut-through.
module s2mm_channel_fifo #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned DEPTH             = 512,
    // Derived from DEPTH; do not override.
    parameter int unsigned ADDR_WIDTH        = $clog2(DEPTH),
    parameter bit          STORE_AND_FORWARD = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    s2mm_channel_fifo_if.slave io_bus
);
    localparam logic [ADDR_WIDTH:0] LevelFull = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_last_mem;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [ADDR_WIDTH:0]   r_pkt_count;
    logic [15:0]           r_underflow_cnt;
    logic                  r_cut_through;
    logic                  r_ready_en;

    logic                  w_full;
    logic                  w_wr;
    logic                  w_pop;
    logic                  w_empty_stb;
    logic                  w_head_last;
    logic                  w_pkt_in;
    logic                  w_pkt_out;
    logic [ADDR_WIDTH:0]   w_level_d;
    logic [ADDR_WIDTH:0]   w_pkt_count_d;
    logic [15:0]           w_underflow_cnt_d;
    logic                  w_cut_through_d;

    assign w_full      = (r_level == LevelFull);
    // r_ready_en keeps tready low during reset and until the first edge after release.
    assign io_bus.SRC_AXIS_tready_out = r_ready_en && !w_full;
    assign w_wr        = io_bus.SRC_AXIS_tvalid_in && io_bus.SRC_AXIS_tready_out;
    assign w_pop       = io_bus.fifo_r_stb_in && (r_level != '0);
    // The filter strobes one cycle after sampling, so a strobe on empty is expected, not fatal.
    assign w_empty_stb = io_bus.fifo_r_stb_in && (r_level == '0);
    assign w_head_last = r_last_mem[r_rd_ptr];
    assign w_pkt_in    = w_wr && io_bus.SRC_AXIS_tlast_in;
    assign w_pkt_out   = w_pop && w_head_last;

    // Head word falls through; gated to zero while nothing is stored.
    assign io_bus.fifo_data_out     = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign io_bus.fifo_last_out     = (r_level != '0) ? w_head_last : 1'b0;
    assign io_bus.fifo_not_empty_out = STORE_AND_FORWARD ?
                                       ((r_pkt_count != '0) || r_cut_through) :
                                       (r_level != '0);
    assign io_bus.fifo_level_out    = r_level;
    assign io_bus.pkt_count_out     = r_pkt_count;
    assign io_bus.underflow_cnt_out = r_underflow_cnt;

    // Storage array; unreset because every read of it is qualified by the level.
    always_ff @(posedge clk_in) begin
        if (w_wr) begin
            r_mem[r_wr_ptr]      <= io_bus.SRC_AXIS_tdata_in;
            r_last_mem[r_wr_ptr] <= io_bus.SRC_AXIS_tlast_in;
        end
    end

    // Next-state for occupancy, packet count, cut-through flag and underflow counter.
    always_comb begin
        w_level_d         = r_level;
        w_pkt_count_d     = r_pkt_count;
        w_cut_through_d   = r_cut_through;
        w_underflow_cnt_d = r_underflow_cnt;

        case ({w_wr, w_pop})
            2'b10:   w_level_d = r_level + (ADDR_WIDTH + 1)'(1);
            2'b01:   w_level_d = r_level - (ADDR_WIDTH + 1)'(1);
            default: w_level_d = r_level;
        endcase

        w_pkt_count_d = r_pkt_count + {{ADDR_WIDTH{1'b0}}, w_pkt_in}
                                    - {{ADDR_WIDTH{1'b0}}, w_pkt_out};

        // Full with no complete packet would deadlock: stream it out until its last word leaves.
        if (w_pkt_out) begin
            w_cut_through_d = 1'b0;
        end else if (w_full && (r_pkt_count == '0)) begin
            w_cut_through_d = 1'b1;
        end

        if (w_empty_stb && (r_underflow_cnt != 16'hFFFF)) begin
            w_underflow_cnt_d = r_underflow_cnt + 16'd1;
        end
    end

    // Control state registers; reset discards everything including a partial packet.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_pkt_count     <= '0;
            r_underflow_cnt <= '0;
            r_cut_through   <= 1'b0;
            r_ready_en      <= 1'b0;
        end else begin
            r_ready_en      <= 1'b1;
            r_level         <= w_level_d;
            r_pkt_count     <= w_pkt_count_d;
            r_cut_through   <= w_cut_through_d;
            r_underflow_cnt <= w_underflow_cnt_d;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_s2mm_channel_fifo.sv
// Scoreboard bench for s2mm_channel_fifo: one store-and-forward and one cut-through
// instance (DEPTH=8); a queue-based model of the stored words predicts every output.
module tb_s2mm_channel_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // sel=0 drives the store-and-forward instance, sel=1 the cut-through one.
    logic          sel     = 1'b0;
    logic          t_valid = 1'b0;
    logic          t_last  = 1'b0;
    logic [DW-1:0] t_data  = '0;
    logic          r_stb   = 1'b0;

    s2mm_channel_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_sf ();
    s2mm_channel_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_ct ();

    s2mm_channel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_AND_FORWARD(1'b1)) u_sf (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .io_bus  (bus_sf)
    );
    s2mm_channel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_AND_FORWARD(1'b0)) u_ct (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .io_bus  (bus_ct)
    );

    assign bus_sf.SRC_AXIS_tdata_in  = t_data;
    assign bus_sf.SRC_AXIS_tlast_in  = t_last;
    assign bus_sf.SRC_AXIS_tvalid_in = t_valid && !sel;
    assign bus_sf.fifo_r_stb_in      = r_stb && !sel;
    assign bus_ct.SRC_AXIS_tdata_in  = t_data;
    assign bus_ct.SRC_AXIS_tlast_in  = t_last;
    assign bus_ct.SRC_AXIS_tvalid_in = t_valid && sel;
    assign bus_ct.fifo_r_stb_in      = r_stb && sel;

    wire          d_ready = sel ? bus_ct.SRC_AXIS_tready_out : bus_sf.SRC_AXIS_tready_out;
    wire [DW-1:0] d_data  = sel ? bus_ct.fifo_data_out      : bus_sf.fifo_data_out;
    wire          d_last  = sel ? bus_ct.fifo_last_out      : bus_sf.fifo_last_out;
    wire          d_ne    = sel ? bus_ct.fifo_not_empty_out : bus_sf.fifo_not_empty_out;
    wire [AW:0]   d_level = sel ? bus_ct.fifo_level_out     : bus_sf.fifo_level_out;
    wire [AW:0]   d_pkts  = sel ? bus_ct.pkt_count_out      : bus_sf.pkt_count_out;
    wire [15:0]   d_under = sel ? bus_ct.underflow_cnt_out  : bus_sf.underflow_cnt_out;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The FIFO is a queue of {last, data}; level is its size, packets are the lasts inside it.
    logic [DW:0] exp_q[$];
    int unsigned m_under  = 0;
    bit          m_ct     = 1'b0;
    bit          m_rdy_en = 1'b0;

    function automatic int m_pkts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][DW]) n++;
        return n;
    endfunction

    int m_lvl;
    bit m_pop;
    bit m_wr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_under  <= 0;
            m_ct     <= 1'b0;
            m_rdy_en <= 1'b0;
        end else begin
            m_lvl = exp_q.size();
            m_pop = r_stb && (m_lvl != 0);
            m_wr  = t_valid && m_rdy_en && (m_lvl != DEPTH);
            if (r_stb && (m_lvl == 0) && (m_under != 16'hFFFF)) m_under <= m_under + 1;
            if (m_pop && exp_q[0][DW]) m_ct <= 1'b0;
            else if ((m_lvl == DEPTH) && (m_pkts() == 0)) m_ct <= 1'b1;
            if (m_pop) void'(exp_q.pop_front());
            if (m_wr) exp_q.push_back({t_last, t_data});
            m_rdy_en <= 1'b1;
        end
    end

    // Monitor: every cycle the DUT's visible outputs are compared against the model.
    int  e_lvl;
    bit  e_ne;
    always @(negedge clk) begin
        e_lvl = exp_q.size();
        e_ne  = sel ? (e_lvl != 0) : ((m_pkts() != 0) || m_ct);
        check("tready", 64'(d_ready), 64'(m_rdy_en && (e_lvl != DEPTH)));
        check("level", 64'(d_level), 64'(e_lvl));
        check("pkt_count", 64'(d_pkts), 64'(m_pkts()));
        check("not_empty", 64'(d_ne), 64'(e_ne));
        check("underflow", 64'(d_under), 64'(m_under));
        if (e_lvl != 0) check("head", 64'({d_last, d_data}), 64'(exp_q[0]));
        else if (!rst_n) check("reset_head", 64'({d_last, d_data}), 64'(0));
    end

    // ---------------- stimulus ----------------
    logic [DW:0] tx_q[$];

    task automatic do_reset(input bit s);
        t_valid = 1'b0;
        r_stb   = 1'b0;
        rst_n   = 1'b0;
        sel     = s;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int budget, input int vpct);
        int n = 0;
        bit acc;
        while ((tx_q.size() != 0) && (n < budget)) begin
            t_valid = ($urandom_range(99) < vpct);
            t_data  = tx_q[0][DW-1:0];
            t_last  = tx_q[0][DW];
            @(negedge clk);
            acc = t_valid && d_ready;
            @(posedge clk);
            #1;
            if (acc) void'(tx_q.pop_front());
            n++;
        end
        t_valid = 1'b0;
        if (tx_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL send_timeout left=%0d want=0", tx_q.size());
            tx_q.delete();
        end
    endtask

    task automatic pop_run(input int ncyc, input int ppct);
        repeat (ncyc) begin
            r_stb = d_ne && ($urandom_range(99) < ppct);
            @(posedge clk);
            #1;
        end
        r_stb = 1'b0;
    endtask

    initial begin
        // Reset and release: monitor checks tready/not_empty/level while held and after.
        do_reset(1'b0);

        // Store-and-forward: nothing advertised until the last word lands.
        for (int i = 0; i < 4; i++) tx_q.push_back({(i == 3), 32'hA0 + 32'(i)});
        send(10, 100);
        check("sf_ne_after_last", 64'(d_ne), 64'(1));
        check("sf_level4", 64'(d_level), 64'(4));
        check("sf_pkt1", 64'(d_pkts), 64'(1));
        pop_run(6, 100);
        check("sf_drained", 64'(d_level), 64'(0));

        // Fill the cut-through instance; ninth word waits for a pop to free a slot.
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) tx_q.push_back({1'b0, 32'h100 + 32'(i)});
        fork
            send(20, 100);
            begin
                repeat (10) @(posedge clk);
                #1;
                check("fill_level8", 64'(d_level), 64'(8));
                check("fill_tready0", 64'(d_ready), 64'(0));
                r_stb = 1'b1;
                @(posedge clk);
                #1 r_stb = 1'b0;
            end
        join
        check("fill_refill8", 64'(d_level), 64'(8));
        pop_run(12, 100);

        // Underflow: one word, strobe held two cycles.
        do_reset(1'b0);
        tx_q.push_back({1'b1, 32'h55});
        send(5, 100);
        r_stb = 1'b1;
        repeat (2) @(posedge clk);
        #1 r_stb = 1'b0;
        check("uf_cnt", 64'(d_under), 64'(1));
        check("uf_level0", 64'(d_level), 64'(0));

        // Oversize 12-word packet forces cut-through, then a 2-word packet waits for its last.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) tx_q.push_back({(i == 11), 32'h200 + 32'(i)});
        tx_q.push_back({1'b0, 32'h300});
        tx_q.push_back({1'b1, 32'h301});
        fork
            send(80, 100);
            pop_run(80, 100);
        join
        check("os_drained", 64'(d_level), 64'(0));

        // Wrap: 3*DEPTH+3 random words with random valid, last and pop on both instances.
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            for (int i = 0; i < 3 * DEPTH + 3; i++) begin
                tx_q.push_back({(i == 3 * DEPTH + 2) || ($urandom_range(3) == 0), $urandom()});
            end
            fork
                send(600, 60);
                pop_run(600, 50);
            join
            pop_run(40, 100);
            check("wrap_drained", 64'(d_level), 64'(0));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
